// File: rtl/ifmap_scratchpad_datapath.sv
// Circular IFMap scratchpad with window start/offset/length bookkeeping.
// Serves one filter window at a time and tracks row position for stride/next-row steps.
module ifmap_scratchpad_datapath #(
    parameter int unsigned POINTER_SIZE = 8,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned IFMAP_SIZE   = 16,
    parameter int unsigned STRIDE_SIZE  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write_counter_en,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    read_en,
    input  logic                    stride_en,
    input  logic                    ld_start_row,
    input  logic [STRIDE_SIZE-1:0]  stride,
    input  logic [POINTER_SIZE-1:0] filter_len,
    input  logic [POINTER_SIZE-1:0] row_len,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic [POINTER_SIZE-1:0] read_pointer,
    output logic [POINTER_SIZE-1:0] write_pointer,
    output logic [POINTER_SIZE-1:0] len_counter,
    output logic                    full,
    output logic                    co_filter,
    output logic                    end_row,
    output logic                    next_row
);

    localparam int unsigned AW = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;
    localparam int unsigned EW = POINTER_SIZE + 2;
    typedef logic [EW-1:0] ext_t;
    localparam ext_t DEPTH = ext_t'(IFMAP_SIZE);

    logic [POINTER_SIZE-1:0] wp_q, wp_d;
    logic [POINTER_SIZE-1:0] start_q, start_d;
    logic [POINTER_SIZE-1:0] offset_q, offset_d;
    logic [POINTER_SIZE-1:0] pos_q, pos_d;
    logic [POINTER_SIZE-1:0] len_q, len_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    dout_valid_q, dout_valid_d;
    logic [DATA_WIDTH-1:0]   mem [IFMAP_SIZE];

    logic wr_en;
    logic hit;
    logic last_elem;
    ext_t dec;
    ext_t len_inc;

    // Operands are always below IFMAP_SIZE, so a single conditional subtract wraps.
    function automatic logic [POINTER_SIZE-1:0] wrap_add(input logic [POINTER_SIZE-1:0] a,
                                                        input ext_t b);
        ext_t s;
        s = ext_t'(a) + b;
        if (s >= DEPTH) begin
            s = s - DEPTH;
        end
        return s[POINTER_SIZE-1:0];
    endfunction

    always_comb begin
        read_pointer = wrap_add(start_q, ext_t'(offset_q));
        wr_en        = write_counter_en && !full;
        hit          = read_en && (offset_q < len_q);
        last_elem    = (ext_t'(offset_q) + ext_t'(1)) == ext_t'(filter_len);
        co_filter    = hit && last_elem;
        end_row      = (ext_t'(pos_q) + ext_t'(stride) + ext_t'(filter_len)) > ext_t'(row_len);
        next_row     = co_filter && end_row;
    end

    always_comb begin
        wp_d         = wp_q;
        start_d      = start_q;
        offset_d     = offset_q;
        pos_d        = pos_q;
        dout_d       = dout_q;
        dout_valid_d = hit;
        dec          = '0;
        len_inc      = ext_t'(len_q) + ext_t'(wr_en);

        if (wr_en) begin
            wp_d = wrap_add(wp_q, ext_t'(1));
        end

        if (hit) begin
            dout_d   = mem[read_pointer[AW-1:0]];
            offset_d = last_elem ? '0 : offset_q + 1'b1;
        end

        if (ld_start_row) begin
            dec      = (row_len >= pos_q) ? ext_t'(row_len) - ext_t'(pos_q) : '0;
            pos_d    = '0;
            offset_d = '0;
        end else if (stride_en) begin
            dec      = ext_t'(stride);
            pos_d    = pos_q + POINTER_SIZE'(stride);
            offset_d = '0;
        end

        start_d = wrap_add(start_q, dec);
        // Over-large decrements are a controller fault; clamp rather than wrap the count.
        if (dec > len_inc) begin
            len_d = '0;
        end else begin
            len_d = POINTER_SIZE'(len_inc - dec);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q         <= '0;
            start_q      <= '0;
            offset_q     <= '0;
            pos_q        <= '0;
            len_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            wp_q         <= wp_d;
            start_q      <= start_d;
            offset_q     <= offset_d;
            pos_q        <= pos_d;
            len_q        <= len_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp_q[AW-1:0]] <= din;
        end
    end

    assign write_pointer = wp_q;
    assign len_counter   = len_q;
    assign full          = ({1'b0, len_q} >= DEPTH[POINTER_SIZE:0]);
    assign dout          = dout_q;
    assign dout_valid    = dout_valid_q;

endmodule

// File: tb/tb_ifmap_scratchpad_datapath.sv
// Directed bench for the IFMap scratchpad: fill/wrap, window reads, strides,
// row jump, concurrent write+stride, mid-window reset and length saturation.
module tb_ifmap_scratchpad_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_counter_en;
    logic [15:0] din;
    logic        read_en;
    logic        stride_en;
    logic        ld_start_row;
    logic [2:0]  stride;
    logic [7:0]  filter_len;
    logic [7:0]  row_len;
    logic [15:0] dout;
    logic        dout_valid;
    logic [7:0]  read_pointer;
    logic [7:0]  write_pointer;
    logic [7:0]  len_counter;
    logic        full;
    logic        co_filter;
    logic        end_row;
    logic        next_row;

    int checks = 0;
    int errors = 0;

    ifmap_scratchpad_datapath #(
        .POINTER_SIZE(8),
        .DATA_WIDTH  (16),
        .IFMAP_SIZE  (16),
        .STRIDE_SIZE (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .write_counter_en(write_counter_en),
        .din             (din),
        .read_en         (read_en),
        .stride_en       (stride_en),
        .ld_start_row    (ld_start_row),
        .stride          (stride),
        .filter_len      (filter_len),
        .row_len         (row_len),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .read_pointer    (read_pointer),
        .write_pointer   (write_pointer),
        .len_counter     (len_counter),
        .full            (full),
        .co_filter       (co_filter),
        .end_row         (end_row),
        .next_row        (next_row)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        write_counter_en = 1'b0;
        read_en = 1'b0;
        stride_en = 1'b0;
        ld_start_row = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    // Reads one window of n elements expecting data base, base+1, ...
    task automatic read_window(input string name, input int n, input logic [15:0] base,
                               input logic exp_next_row);
        for (int k = 0; k < n; k++) begin
            read_en = 1'b1;
            #1;
            checks++;
            if (co_filter !== (k == n - 1)) begin
                errors++;
                $display("FAIL %s co_filter[%0d]: got %b expected %b", name, k, co_filter, (k == n - 1));
            end
            checks++;
            if (next_row !== (exp_next_row && (k == n - 1))) begin
                errors++;
                $display("FAIL %s next_row[%0d]: got %b expected %b", name, k, next_row,
                         exp_next_row && (k == n - 1));
            end
            cyc();
            checks++;
            if (dout_valid !== 1'b1 || dout !== base + 16'(k)) begin
                errors++;
                $display("FAIL %s dout[%0d]: got %0d/v%b expected %0d/v1", name, k, dout, dout_valid,
                         base + 16'(k));
            end
        end
        read_en = 1'b0;
    endtask

    task automatic test_reset();
        din = '0;
        stride = 3'd2;
        filter_len = 8'd3;
        row_len = 8'd8;
        do_reset();
        checks++;
        if (write_pointer !== 8'd0 || len_counter !== 8'd0 || read_pointer !== 8'd0 ||
            dout !== 16'd0 || dout_valid !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: wp=%0d len=%0d rp=%0d dout=%0d v=%b full=%b expected all 0",
                     write_pointer, len_counter, read_pointer, dout, dout_valid, full);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            write_counter_en = 1'b1;
            din = 16'(i);
            cyc();
        end
        write_counter_en = 1'b0;
        checks++;
        if (write_pointer !== 8'd0 || len_counter !== 8'd16 || full !== 1'b1) begin
            errors++;
            $display("FAIL fill: wp=%0d len=%0d full=%b expected 0/16/1", write_pointer, len_counter, full);
        end
        write_counter_en = 1'b1;
        din = 16'd99;
        cyc();
        write_counter_en = 1'b0;
        checks++;
        if (write_pointer !== 8'd0 || len_counter !== 8'd16) begin
            errors++;
            $display("FAIL drop_when_full: wp=%0d len=%0d expected 0/16", write_pointer, len_counter);
        end
    endtask

    task automatic test_window_reads();
        checks++;
        if (end_row !== 1'b0) begin
            errors++;
            $display("FAIL end_row_pos0: got %b expected 0", end_row);
        end
        read_window("win0", 3, 16'd0, 1'b0);
        cyc();
        checks++;
        if (dout_valid !== 1'b0 || read_pointer !== 8'd0) begin
            errors++;
            $display("FAIL idle_after_win0: v=%b rp=%0d expected 0/0", dout_valid, read_pointer);
        end
    endtask

    task automatic test_stride();
        stride_en = 1'b1;
        cyc();
        stride_en = 1'b0;
        checks++;
        if (len_counter !== 8'd14 || read_pointer !== 8'd2 || end_row !== 1'b0) begin
            errors++;
            $display("FAIL stride1: len=%0d rp=%0d end_row=%b expected 14/2/0", len_counter, read_pointer,
                     end_row);
        end
        read_window("win2", 3, 16'd2, 1'b0);
    endtask

    task automatic test_end_row();
        stride_en = 1'b1;
        cyc();
        stride_en = 1'b0;
        checks++;
        if (len_counter !== 8'd12 || read_pointer !== 8'd4 || end_row !== 1'b1) begin
            errors++;
            $display("FAIL stride2: len=%0d rp=%0d end_row=%b expected 12/4/1", len_counter, read_pointer,
                     end_row);
        end
        read_window("win4", 3, 16'd4, 1'b1);
        ld_start_row = 1'b1;
        stride_en = 1'b1;
        cyc();
        ld_start_row = 1'b0;
        stride_en = 1'b0;
        checks++;
        if (len_counter !== 8'd8 || read_pointer !== 8'd8 || end_row !== 1'b0) begin
            errors++;
            $display("FAIL ld_start_row: len=%0d rp=%0d end_row=%b expected 8/8/0", len_counter,
                     read_pointer, end_row);
        end
        read_window("row1", 3, 16'd8, 1'b0);
    endtask

    task automatic test_write_and_stride();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            write_counter_en = 1'b1;
            din = 16'(100 + i);
            cyc();
        end
        checks++;
        if (len_counter !== 8'd5 || write_pointer !== 8'd5) begin
            errors++;
            $display("FAIL prefill5: len=%0d wp=%0d expected 5/5", len_counter, write_pointer);
        end
        din = 16'd105;
        stride_en = 1'b1;
        cyc();
        write_counter_en = 1'b0;
        stride_en = 1'b0;
        checks++;
        if (len_counter !== 8'd4 || write_pointer !== 8'd6 || read_pointer !== 8'd2 || full !== 1'b0) begin
            errors++;
            $display("FAIL write_and_stride: len=%0d wp=%0d rp=%0d full=%b expected 4/6/2/0", len_counter,
                     write_pointer, read_pointer, full);
        end
        read_window("win_ws", 3, 16'd102, 1'b0);
    endtask

    task automatic test_reset_mid();
        read_en = 1'b1;
        cyc();
        read_en = 1'b0;
        checks++;
        if (read_pointer !== 8'd3) begin
            errors++;
            $display("FAIL mid_offset: rp=%0d expected 3", read_pointer);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (write_pointer !== 8'd0 || len_counter !== 8'd0 || read_pointer !== 8'd0 || dout !== 16'd0 ||
            dout_valid !== 1'b0 || full !== 1'b0 || co_filter !== 1'b0 || end_row !== 1'b0 ||
            next_row !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: wp=%0d len=%0d rp=%0d dout=%0d v=%b full=%b co=%b er=%b nr=%b expected 0",
                     write_pointer, len_counter, read_pointer, dout, dout_valid, full, co_filter, end_row,
                     next_row);
        end
        filter_len = 8'd1;
        write_counter_en = 1'b1;
        din = 16'hABCD;
        cyc();
        write_counter_en = 1'b0;
        read_window("post_rst_f1", 1, 16'hABCD, 1'b0);

        do_reset();
        filter_len = 8'd3;
        write_counter_en = 1'b1;
        din = 16'h1234;
        cyc();
        write_counter_en = 1'b0;
        read_en = 1'b1;
        #1;
        checks++;
        if (co_filter !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_f3_co: got %b expected 0", co_filter);
        end
        cyc();
        read_en = 1'b0;
        checks++;
        if (dout !== 16'h1234 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_f3_dout: got %h/v%b expected 1234/v1", dout, dout_valid);
        end
        read_en = 1'b1;
        #1;
        checks++;
        if (co_filter !== 1'b0) begin
            errors++;
            $display("FAIL miss_co: got %b expected 0", co_filter);
        end
        cyc();
        read_en = 1'b0;
        checks++;
        if (dout_valid !== 1'b0 || dout !== 16'h1234 || read_pointer !== 8'd1) begin
            errors++;
            $display("FAIL miss: v=%b dout=%h rp=%0d expected 0/1234/1", dout_valid, dout, read_pointer);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        write_counter_en = 1'b1;
        din = 16'd7;
        cyc();
        write_counter_en = 1'b0;
        stride = 3'd3;
        stride_en = 1'b1;
        cyc();
        stride_en = 1'b0;
        checks++;
        if (len_counter !== 8'd0 || read_pointer !== 8'd3 || write_pointer !== 8'd1) begin
            errors++;
            $display("FAIL saturate: len=%0d rp=%0d wp=%0d expected 0/3/1", len_counter, read_pointer,
                     write_pointer);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_window_reads();
        test_stride();
        test_end_row();
        test_write_and_stride();
        test_reset_mid();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
